// File: rtl/student_apb_guard_pkg.sv
// rtl/student_apb_guard_pkg.sv - FSM state encoding and default timeout for student_apb_guard
package student_apb_guard_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StSetup  = 3'd1;
  localparam state_t StAccess = 3'd2;
  localparam state_t StResp   = 3'd3;
  localparam state_t StFenced = 3'd4;

  localparam int unsigned DefaultTimeoutCycles = 256;

endpackage

// File: rtl/student_apb_guard_timer.sv
// rtl/student_apb_guard_timer.sv - ACCESS-phase wait counter; hit flags the last permitted wait cycle
module student_apb_guard_timer #(
  parameter int unsigned Limit = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear,
  input  logic enable,
  output logic hit
);

  logic [15:0] count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  assign hit = (count == 16'(Limit - 1));

endmodule

// File: rtl/student_apb_guard.sv
// rtl/student_apb_guard.sv - APB bridge isolating a student peripheral; STUDENT_APB_GUARD_TIMEOUT_EN adds the timeout fence
module student_apb_guard
  import student_apb_guard_pkg::*;
#(
  parameter int unsigned ApbAddrWidth  = 12,
  parameter int unsigned ApbDataWidth  = 32,
  parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    s_psel_i,
  input  logic                    s_penable_i,
  input  logic [ApbAddrWidth-1:0] s_paddr_i,
  input  logic [ApbDataWidth-1:0] s_pwdata_i,
  output logic                    s_pready_o,
  output logic                    s_pslverr_o,
  output logic [ApbDataWidth-1:0] s_prdata_o,
  output logic                    m_psel_o,
  output logic                    m_penable_o,
  output logic [ApbAddrWidth-1:0] m_paddr_o,
  output logic [ApbDataWidth-1:0] m_pwdata_o,
  input  logic                    m_pready_i,
  input  logic                    m_pslverr_i,
  input  logic [ApbDataWidth-1:0] m_prdata_i,
  input  logic                    irq_i,
  output logic                    irq_o,
  output logic                    timeout_o
);

  state_t                  state;
  logic [ApbAddrWidth-1:0] addr_q;
  logic [ApbDataWidth-1:0] wdata_q;
  logic [ApbDataWidth-1:0] rdata_q;
  logic                    err_q;
  logic                    fence_resp;
  logic                    irq_q;
  logic                    timeout_q;
  logic                    limit_hit;
  logic                    host_setup;

  assign host_setup = s_psel_i && !s_penable_i;

`ifdef STUDENT_APB_GUARD_TIMEOUT_EN
  student_apb_guard_timer #(
    .Limit (TimeoutCycles)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clear  (state == StSetup),
    .enable ((state == StAccess) && !m_pready_i),
    .hit    (limit_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_q <= 1'b0;
    end else if ((state == StAccess) && !m_pready_i && limit_hit) begin
      timeout_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TimeoutCycles;
  assign limit_hit  = 1'b0;
  assign timeout_q  = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= StIdle;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      fence_resp <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      fence_resp <= 1'b0;
      irq_q      <= irq_i;
      case (state)
        StIdle: begin
          if (host_setup) begin
            addr_q  <= s_paddr_i;
            wdata_q <= s_pwdata_i;
            state   <= StSetup;
          end
        end
        StSetup: state <= StAccess;
        StAccess: begin
          // A ready student wins over a coincident timeout
          if (m_pready_i) begin
            rdata_q <= m_prdata_i;
            err_q   <= m_pslverr_i;
            state   <= StResp;
          end else if (limit_hit) begin
            fence_resp <= 1'b1;
            state      <= StFenced;
          end
        end
        StResp: state <= StIdle;
        StFenced: fence_resp <= host_setup;
        default: state <= StIdle;
      endcase
    end
  end

  assign m_psel_o    = (state == StSetup) || (state == StAccess);
  assign m_penable_o = (state == StAccess);
  assign m_paddr_o   = m_psel_o ? addr_q : '0;
  assign m_pwdata_o  = m_psel_o ? wdata_q : '0;
  assign s_pready_o  = (state == StResp) || fence_resp;
  assign s_pslverr_o = ((state == StResp) && err_q) || fence_resp;
  assign s_prdata_o  = (state == StResp) ? rdata_q : '0;
  assign timeout_o   = timeout_q;
  assign irq_o       = irq_q && !timeout_q;

endmodule

// File: tb/tb_student_apb_guard.sv
// tb/tb_student_apb_guard.sv - timeline-model bench for student_apb_guard; timeout tests need STUDENT_APB_GUARD_TIMEOUT_EN
module tb_student_apb_guard;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_psel = 1'b0, s_penable = 1'b0;
  logic [11:0] s_paddr = '0;
  logic [31:0] s_pwdata = '0;
  logic        s_pready, s_pslverr;
  logic [31:0] s_prdata;
  logic        m_psel, m_penable;
  logic [11:0] m_paddr;
  logic [31:0] m_pwdata;
  logic        m_pready = 1'b0, m_pslverr = 1'b0;
  logic [31:0] m_prdata = '0;
  logic        irq_i = 1'b0, irq_o, timeout;

  student_apb_guard #(
    .ApbAddrWidth (12),
    .ApbDataWidth (32),
    .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_psel_i(s_psel), .s_penable_i(s_penable), .s_paddr_i(s_paddr), .s_pwdata_i(s_pwdata),
    .s_pready_o(s_pready), .s_pslverr_o(s_pslverr), .s_prdata_o(s_prdata),
    .m_psel_o(m_psel), .m_penable_o(m_penable), .m_paddr_o(m_paddr), .m_pwdata_o(m_pwdata),
    .m_pready_i(m_pready), .m_pslverr_i(m_pslverr), .m_prdata_i(m_prdata),
    .irq_i(irq_i), .irq_o(irq_o), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transaction being modelled: relative cycle r = cyc - t0, host SETUP presented at r = 0
  bit          active = 1'b0;
  bit          x_fence = 1'b0;
  int          t0 = 0, x_n = 0;
  logic [11:0] x_addr = '0;
  logic [31:0] x_wd = '0, x_rd = '0;
  logic        x_err = 1'b0;
  bit          exp_fenced = 1'b0;
  logic        irq_seen;

  int          pen_cycles, psel_cycles, resp_rel;
  logic [31:0] resp_data;
  logic        resp_err;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) irq_seen <= 1'b0;
    else        irq_seen <= irq_i;

  function automatic bit times_out(input int n);
`ifdef STUDENT_APB_GUARD_TIMEOUT_EN
    return n > T;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int eff_n(input int n);
    return times_out(n) ? T : n;
  endfunction

  int          r;
  logic        e_psel, e_pen, e_rdy, e_err, to;
  logic [31:0] e_rdata;

  always @(negedge clk) begin
    e_psel = 0; e_pen = 0; e_rdy = 0; e_err = 0; e_rdata = '0; to = 0;
    if (rst_n && active) begin
      r = cyc - t0;
      if (x_fence) begin
        e_rdy = (r == 1);
        e_err = (r == 1);
      end else begin
        to      = times_out(x_n);
        e_psel  = (r >= 1) && (r <= eff_n(x_n) + 1);
        e_pen   = (r >= 2) && (r <= eff_n(x_n) + 1);
        e_rdy   = (r == eff_n(x_n) + 2);
        e_err   = e_rdy && (to || x_err);
        e_rdata = (e_rdy && !to) ? x_rd : 32'h0;
        if (to && r >= eff_n(x_n) + 2) exp_fenced = 1'b1;
      end
      if (m_penable) pen_cycles++;
      if (m_psel) psel_cycles++;
      if (s_pready) begin
        resp_rel = r; resp_data = s_prdata; resp_err = s_pslverr;
      end
    end
    chk("m_psel", m_psel, e_psel);
    chk("m_penable", m_penable, e_pen);
    chk("s_pready", s_pready, e_rdy);
    chk("s_pslverr", s_pslverr, e_err);
    chk("s_prdata", s_prdata, e_rdata);
    chk("timeout_o", timeout, rst_n && exp_fenced);
    chk("irq_o", irq_o, rst_n && irq_seen && !exp_fenced);
    if (e_psel) begin
      chk("m_paddr", m_paddr, x_addr);
      chk("m_pwdata", m_pwdata, x_wd);
    end
  end

  // Called at negedge+1 of a cycle; returns at negedge+1 of cycle t0+span
  task automatic xfer(input logic [11:0] addr, input logic [31:0] wd, input int n,
                      input logic [31:0] rd, input logic err, input int span, input bit hold);
    t0 = cyc; x_addr = addr; x_wd = wd; x_n = n; x_rd = rd; x_err = err; x_fence = exp_fenced;
    pen_cycles = 0; psel_cycles = 0; resp_rel = -1; resp_data = 32'hFFFFFFFF; resp_err = 1'b0;
    active = 1'b1;
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = addr; s_pwdata = wd;
    for (int k = 1; k <= span; k++) begin
      @(negedge clk); #1;
      s_penable = hold || (k < 2);
      s_psel    = hold || (k < 2);
      s_paddr   = ~addr; s_pwdata = ~wd;
      m_pready  = (k == n + 1);
      m_prdata  = (k == n + 1) ? rd : (32'hDEAD0000 | 32'(k));
      m_pslverr = (k == n + 1) ? err : 1'b1;
    end
    if (span >= (x_fence ? 1 : eff_n(n) + 2)) begin
      active = 1'b0;
      s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0; m_pslverr = 1'b0;
    end
  endtask

  task automatic pulse_reset(input int cycles_low);
    #2 rst_n = 1'b0;
    active = 1'b0; exp_fenced = 1'b0;
    #1;
    chk("rst_m_psel", m_psel, 0);
    chk("rst_m_penable", m_penable, 0);
    chk("rst_m_paddr", m_paddr, 0);
    chk("rst_m_pwdata", m_pwdata, 0);
    chk("rst_s_pready", s_pready, 0);
    chk("rst_s_pslverr", s_pslverr, 0);
    chk("rst_s_prdata", s_prdata, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_irq", irq_o, 0);
    s_psel = 1'b0; s_penable = 1'b0; m_pready = 1'b0; m_pslverr = 1'b0; irq_i = 1'b0;
    repeat (cycles_low) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic irq_pulse(input logic want);
    irq_i = 1'b1;
    @(negedge clk); #1;
    chk("irq_pulse_hi", irq_o, want);
    irq_i = 1'b0;
    @(negedge clk); #1;
    chk("irq_pulse_lo", irq_o, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("init_m_psel", m_psel, 0);
    chk("init_s_pready", s_pready, 0);
    chk("init_timeout", timeout, 0);
    rst_n = 1'b1;

    xfer(12'h004, 32'h0, 1, 32'hCAFE0001, 1'b0, 4, 1'b1);
    chk("read_latency", resp_rel, 3);
    chk("read_data", resp_data, 32'hCAFE0001);
    chk("read_err", resp_err, 0);

    irq_pulse(1'b1);

    xfer(12'hFFC, 32'hA5A55A5A, 2, 32'h12345678, 1'b0, 5, 1'b0);
    chk("drop_latency", resp_rel, 4);
    chk("drop_data", resp_data, 32'h12345678);

    xfer(12'h010, 32'h1, 6, 32'h55AA0000, 1'b1, 9, 1'b1);
    chk("slverr_latency", resp_rel, 8);
    chk("slverr_err", resp_err, 1);
    chk("slverr_timeout", timeout, 0);

    xfer(12'h020, 32'h2, T, 32'h00C0FFEE, 1'b0, T + 3, 1'b1);
    chk("edge_latency", resp_rel, T + 2);
    chk("edge_data", resp_data, 32'h00C0FFEE);
    chk("edge_access_cycles", pen_cycles, T);
    chk("edge_timeout", timeout, 0);

`ifdef STUDENT_APB_GUARD_TIMEOUT_EN
    xfer(12'h030, 32'h3, 1000, 32'h0, 1'b0, T + 3, 1'b1);
    chk("to_access_cycles", pen_cycles, 8);
    chk("to_latency", resp_rel, 10);
    chk("to_err", resp_err, 1);
    chk("to_data", resp_data, 0);
    chk("to_flag", timeout, 1);

    xfer(12'h040, 32'h4, 1, 32'h11111111, 1'b0, 3, 1'b1);
    chk("fence_latency", resp_rel, 1);
    chk("fence_err", resp_err, 1);
    chk("fence_psel_cycles", psel_cycles, 0);
    chk("fence_timeout", timeout, 1);

    irq_pulse(1'b0);
    pulse_reset(2);
`else
    xfer(12'h030, 32'h3, 1000, 32'h0, 1'b0, 30, 1'b1);
    chk("hang_access_cycles", pen_cycles, 29);
    chk("hang_penable", m_penable, 1);
    chk("hang_timeout", timeout, 0);
    pulse_reset(2);
`endif

    xfer(12'h050, 32'h5, 1000, 32'h0, 1'b0, 4, 1'b1);
    chk("mid_penable", m_penable, 1);
    pulse_reset(3);
    xfer(12'h123, 32'h77, 1, 32'h0BADF00D, 1'b0, 4, 1'b1);
    chk("post_rst_latency", resp_rel, 3);
    chk("post_rst_data", resp_data, 32'h0BADF00D);

    repeat (2) @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog expired");
  end

endmodule
